voltage_window_stats: RTL and testbench

//  Downstream consumer of the data_collector converted-voltage byte stream.

---
 rtl/voltage_window_stats.sv | 149 ++++++++++++++
 tb/tb_voltage_window_stats.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/voltage_window_stats.sv
// Window statistics over an 8-bit sample stream: average, minimum and maximum per
// 2**LOG2_WIN samples, hysteretic OV/UV flags, and a valid/ready result register.
module voltage_window_stats #(
  parameter int unsigned LOG2_WIN = 4,
  parameter logic [7:0]  OV_HI    = 8'd220,
  parameter logic [7:0]  OV_LO    = 8'd200,
  parameter logic [7:0]  UV_LO    = 8'd40,
  parameter logic [7:0]  UV_HI    = 8'd60
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] sample_in,
  input  logic       sample_valid,
  input  logic       clear,
  output logic [7:0] avg_out,
  output logic [7:0] min_out,
  output logic [7:0] max_out,
  output logic       result_valid,
  input  logic       result_ready,
  output logic       ovp_flag,
  output logic       uvp_flag,
  output logic       overrun
);
  localparam int unsigned ACC_W = 8 + LOG2_WIN;

  typedef enum logic {IDLE, ACCUM} state_t;
  state_t state_q, state_d;
  logic   fresh;

  logic [ACC_W-1:0]    acc_q, acc_d, acc_base, sum_new;
  logic [LOG2_WIN-1:0] cnt_q, cnt_d;
  logic [7:0]          run_min_q, run_min_d, run_max_q, run_max_d;
  logic [7:0]          min_base, max_base, min_new, max_new, avg_new;
  logic [7:0]          avg_q, avg_d, min_q, min_d, max_q, max_d;
  logic                valid_q, valid_d, ovp_q, ovp_d, uvp_q, uvp_d, ovr_q, ovr_d;
  logic                accept, win_end, xfer;

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    if (clear)       state_d = IDLE;
    else if (accept) state_d = ACCUM;
  end

  // FSM: outputs; in IDLE the running statistics start from their neutral values
  always_comb begin
    fresh = (state_q == IDLE);
  end

  always_comb begin
    accept   = sample_valid & ~clear;
    win_end  = accept & (&cnt_q);
    xfer     = valid_q & result_ready;
    acc_base = fresh ? '0    : acc_q;
    min_base = fresh ? 8'hFF : run_min_q;
    max_base = fresh ? 8'h00 : run_max_q;
    sum_new  = acc_base + {{LOG2_WIN{1'b0}}, sample_in};
    avg_new  = sum_new[ACC_W-1 -: 8];
    min_new  = (sample_in < min_base) ? sample_in : min_base;
    max_new  = (sample_in > max_base) ? sample_in : max_base;
  end

  always_comb begin
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    run_min_d = run_min_q;
    run_max_d = run_max_q;
    avg_d     = avg_q;
    min_d     = min_q;
    max_d     = max_q;
    valid_d   = valid_q;
    ovp_d     = ovp_q;
    uvp_d     = uvp_q;
    ovr_d     = ovr_q;
    if (clear) begin
      acc_d     = '0;
      cnt_d     = '0;
      run_min_d = 8'hFF;
      run_max_d = 8'h00;
      valid_d   = 1'b0;
      ovr_d     = 1'b0;
    end else if (win_end) begin
      acc_d     = '0;
      cnt_d     = '0;
      run_min_d = 8'hFF;
      run_max_d = 8'h00;
      avg_d     = avg_new;
      min_d     = min_new;
      max_d     = max_new;
      valid_d   = 1'b1;
      // Overwriting a result the consumer has not taken this edge is an overrun
      if (valid_q && !result_ready) ovr_d = 1'b1;
      if (!ovp_q && avg_new > OV_HI)      ovp_d = 1'b1;
      else if (ovp_q && avg_new < OV_LO)  ovp_d = 1'b0;
      if (!uvp_q && avg_new < UV_LO)      uvp_d = 1'b1;
      else if (uvp_q && avg_new > UV_HI)  uvp_d = 1'b0;
    end else begin
      if (accept) begin
        acc_d     = sum_new;
        cnt_d     = cnt_q + LOG2_WIN'(1);
        run_min_d = min_new;
        run_max_d = max_new;
      end
      if (xfer) valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q     <= '0;
      cnt_q     <= '0;
      run_min_q <= 8'hFF;
      run_max_q <= 8'h00;
      avg_q     <= 8'h00;
      min_q     <= 8'h00;
      max_q     <= 8'h00;
      valid_q   <= 1'b0;
      ovp_q     <= 1'b0;
      uvp_q     <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      run_min_q <= run_min_d;
      run_max_q <= run_max_d;
      avg_q     <= avg_d;
      min_q     <= min_d;
      max_q     <= max_d;
      valid_q   <= valid_d;
      ovp_q     <= ovp_d;
      uvp_q     <= uvp_d;
      ovr_q     <= ovr_d;
    end
  end

  assign avg_out      = avg_q;
  assign min_out      = min_q;
  assign max_out      = max_q;
  assign result_valid = valid_q;
  assign ovp_flag     = ovp_q;
  assign uvp_flag     = uvp_q;
  assign overrun      = ovr_q;
endmodule

// File: tb/tb_voltage_window_stats.sv
// Bench for voltage_window_stats: queue-based window model compared every cycle,
// plus hand-computed expectations for the directed scenarios.
module tb_voltage_window_stats;
  localparam int WIN = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] sample_in = 8'd0;
  logic       sample_valid = 1'b0;
  logic       clear = 1'b0;
  logic       result_ready = 1'b1;
  logic [7:0] avg_out, min_out, max_out;
  logic       result_valid, ovp_flag, uvp_flag, overrun;

  int checks = 0;
  int errors = 0;

  voltage_window_stats #(
    .LOG2_WIN(2), .OV_HI(8'd200), .OV_LO(8'd180), .UV_LO(8'd40), .UV_HI(8'd60)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sample_in(sample_in), .sample_valid(sample_valid),
    .clear(clear), .avg_out(avg_out), .min_out(min_out), .max_out(max_out),
    .result_valid(result_valid), .result_ready(result_ready),
    .ovp_flag(ovp_flag), .uvp_flag(uvp_flag), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: collect accepted samples of the current window, reduce them at window end
  int win[$];
  int m_avg = 0, m_min = 0, m_max = 0;
  bit m_vld = 0, m_ovp = 0, m_uvp = 0, m_ovr = 0;
  bit m_xfer;
  int sum, mn, mx;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      win.delete();
      m_avg = 0; m_min = 0; m_max = 0;
      m_vld = 0; m_ovp = 0; m_uvp = 0; m_ovr = 0;
    end else if (clear) begin
      win.delete();
      m_vld = 0; m_ovr = 0;
    end else begin
      m_xfer = m_vld && result_ready;
      if (sample_valid) win.push_back(int'(sample_in));
      if (win.size() == WIN) begin
        sum = 0; mn = 255; mx = 0;
        foreach (win[i]) begin
          sum += win[i];
          if (win[i] < mn) mn = win[i];
          if (win[i] > mx) mx = win[i];
        end
        if (m_vld && !m_xfer) m_ovr = 1;
        m_vld = 1;
        m_avg = sum / WIN; m_min = mn; m_max = mx;
        if (m_avg > 200) m_ovp = 1; else if (m_avg < 180) m_ovp = 0;
        if (m_avg < 40)  m_uvp = 1; else if (m_avg > 60)  m_uvp = 0;
        win.delete();
      end else if (m_xfer) m_vld = 0;
    end
  end

  initial forever begin
    @(negedge clk);
    chk("avg_model", avg_out, m_avg);
    chk("min_model", min_out, m_min);
    chk("max_model", max_out, m_max);
    chk("valid_model", result_valid, m_vld);
    chk("ovp_model", ovp_flag, m_ovp);
    chk("uvp_model", uvp_flag, m_uvp);
    chk("overrun_model", overrun, m_ovr);
  end

  task automatic send(input int s);
    @(negedge clk);
    clear = 1'b0; sample_valid = 1'b1; sample_in = 8'(s);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      clear = 1'b0; sample_valid = 1'b0;
    end
  endtask

  task automatic window4(input int a, input int b, input int c, input int d);
    send(a); send(b); send(c); send(d);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_avg", avg_out, 0);
    chk("reset_valid", result_valid, 0);
    chk("reset_min", min_out, 0);
    rst_n = 1'b1;

    // 1. basic window, one-cycle valid with ready high
    window4(10, 20, 30, 40); idle(1);
    chk("t1_avg", avg_out, 25); chk("t1_min", min_out, 10); chk("t1_max", max_out, 40);
    chk("t1_valid", result_valid, 1); chk("t1_uvp", uvp_flag, 1);
    idle(1);
    chk("t1_valid_drop", result_valid, 0);

    // 2. truncation and full-scale
    window4(1, 1, 1, 2); idle(1);
    chk("t2_avg_trunc", avg_out, 1); chk("t2_max", max_out, 2);
    window4(255, 255, 255, 255); idle(1);
    chk("t2_avg_full", avg_out, 255); chk("t2_min_full", min_out, 255);
    chk("t2_ovp", ovp_flag, 1); chk("t2_uvp", uvp_flag, 0);
    idle(2);

    // 3. overwrite while not ready
    result_ready = 1'b0;
    window4(10, 20, 30, 40);
    window4(100, 100, 100, 100); idle(1);
    chk("t3_avg", avg_out, 100); chk("t3_valid", result_valid, 1);
    chk("t3_overrun", overrun, 1);
    result_ready = 1'b1; idle(1);
    chk("t3_valid_after", result_valid, 0); chk("t3_overrun_sticky", overrun, 1);
    @(negedge clk); clear = 1'b1; idle(1);
    chk("t3_overrun_clr", overrun, 0);

    // 4. hysteresis
    window4(210, 210, 210, 210); idle(1); chk("t4_ovp_210", ovp_flag, 1);
    window4(190, 190, 190, 190); idle(1); chk("t4_ovp_190", ovp_flag, 1);
    window4(170, 170, 170, 170); idle(1); chk("t4_ovp_170", ovp_flag, 0);
    window4(30, 30, 30, 30);     idle(1); chk("t4_uvp_30", uvp_flag, 1);
    window4(50, 50, 50, 50);     idle(1); chk("t4_uvp_50", uvp_flag, 1);
    window4(70, 70, 70, 70);     idle(1); chk("t4_uvp_70", uvp_flag, 0);

    // 5. asynchronous reset mid-window
    send(8); send(8); idle(1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_avg", avg_out, 0); chk("t5_rst_min", min_out, 0);
    chk("t5_rst_max", max_out, 0); chk("t5_rst_valid", result_valid, 0);
    @(negedge clk); rst_n = 1'b1;
    window4(8, 8, 8, 8); idle(1);
    chk("t5_avg", avg_out, 8); chk("t5_valid", result_valid, 1);
    idle(1);

    // 6. clear with a same-cycle sample drops the partial window
    send(90); send(20);
    @(negedge clk); clear = 1'b1; sample_valid = 1'b1; sample_in = 8'd200;
    send(50);
    chk("t6_avg_kept", avg_out, 8);
    send(50); send(50); send(50); idle(1);
    chk("t6_avg", avg_out, 50); chk("t6_min", min_out, 50); chk("t6_max", max_out, 50);
    chk("t6_overrun", overrun, 0); chk("t6_valid", result_valid, 1);
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
